adc_seq_ctrl: RTL
=================

ADC_SEQ_CTRL -- requirements
Module: adc_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, meaning number of ADC channels; legal range 1..16.
REQ-002 SHALL have parameter DW, default 14, meaning conversion result width; legal range 8..16.
REQ-003 SHALL have parameter FRAME_LEN, default 24, meaning clk cycles per serial frame after fs; must be >= 16 and >= DW.
REQ-004 SHALL have parameter INIT_WORD, default 16'hA000, meaning ADC init command.
REQ-005 SHALL have parameter CFG_WORD, default 16'hAA40, meaning ADC configuration command.
REQ-006 SHALL have parameter RD_CMD, default 16'hE000, meaning FIFO read command.
REQ-007 SHALL have parameter TIMEOUT, default 4095, meaning maximum clk cycles spent waiting for int_l.
REQ-008 SHALL have ports, clock and reset first: clk in 1 system/serial clock; rst in 1 asynchronous active-low reset; init_req in 1 init pulse; start in 1 sweep-start pulse; stop in 1 continuous-mode stop pulse; cont_mode in 1 auto-restart enable; ch_mask in NUM_CH channel enables; int_l in 1 ADC end-of-conversion, active low, asynchronous; sdi in 1 ADC serial data; sclk out 1 serial clock; fs out 1 frame sync; sdo out 1 serial command; cs_l out 1 chip select; cstart out 1 conversion start; busy out 1 sequencer active; dat_valid out 1 sweep-complete pulse; dat_bus out NUM_CH*DW results, channel k in bits [k*DW +: DW]; timeout_err out 1 timeout pulse.

Function
REQ-009 SHALL drive sclk = clk, cstart = 1, and cs_l = !busy.
REQ-010 SHALL implement FSM states IDLE, INIT, CFG, SEL, WAIT_INT, READ, DONE; busy = (state != IDLE).
REQ-011 Frame: fs high exactly 1 cycle (cycle 0); command shifted MSB first on sdo in cycles 1..16 and sdo = 0 otherwise; frame ends at cycle FRAME_LEN; the next frame's fs occurs at the earliest 1 cycle later.
REQ-012 IDLE: init_req -> INIT, sending one INIT_WORD frame, then IDLE. init_req and start in the same cycle: init_req wins and start is dropped.
REQ-013 IDLE: start with ch_mask != 0 latches ch_mask and cont_mode, then -> CFG (one CFG_WORD frame) -> SEL; start with ch_mask == 0 is ignored.
REQ-014 SEL: one frame per enabled channel, ascending index; word = {ch index[3:0], 12'h000}; then -> WAIT_INT.
REQ-015 SHALL synchronise int_l through 2 flops; WAIT_INT: synchronised falling edge -> READ.
REQ-016 READ: one RD_CMD frame per enabled channel, ascending index; sdi sampled MSB first in cycles 1..DW; at frame end the result is written to that channel's dat_bus slot.
REQ-017 Disabled channels' dat_bus slots SHALL hold their previous values.
REQ-018 DONE: dat_valid pulses 1 cycle, the cycle after the last READ frame ends; then -> SEL if the latched cont_mode = 1 and no stop is pending, else -> IDLE.
REQ-019 stop SHALL be latched at any time while busy; the current sweep completes, then the block returns to IDLE; the latch clears on entering IDLE.
REQ-020 WAIT_INT counter: reaching TIMEOUT cycles -> timeout_err pulses 1 cycle, dat_valid is not asserted, state -> IDLE.
REQ-021 start and init_req while busy SHALL be ignored; ch_mask changes while busy have no effect until the next start.

Reset
REQ-022 While rst = 0: state IDLE; fs, sdo, busy, dat_valid, timeout_err = 0; cs_l = 1; dat_bus all 0; latched mask, cont_mode and stop = 0; int_l synchroniser = 1.
REQ-023 Reset asserted mid-frame SHALL abort immediately; the first post-reset frame starts only on a new init_req or start.

Verification
REQ-024 init_req pulse -> fs at the next cycle, sdo = 1010_0000_0000_0000 over cycles 1..16, back in IDLE at frame end, busy low.
REQ-025 ch_mask = 8'h05, start, int_l low after SEL, sdi model returning 14'h1234 for ch0 and 14'h2ABC for ch2 -> SEL words 16'h0000 and 16'h2000; dat_bus[13:0] = 14'h1234, [41:28] = 14'h2ABC; other slots 0; one dat_valid pulse.
REQ-026 cont_mode = 1, mask = 8'hFF, 3 sweeps, then stop pulse mid-READ -> 3 dat_valid pulses, 4th sweep completes with dat_valid, then IDLE; no extra frames.
REQ-027 start with int_l held high, TIMEOUT = 100 -> timeout_err pulse 100 cycles after entering WAIT_INT, no dat_valid, IDLE.
REQ-028 start and init_req in the same cycle; start during READ; start with mask = 0 -> init frame only; second start ignored; third start produces no fs.
REQ-029 rst low during a READ frame -> all outputs at reset values within the same cycle; no fs until a new start.

Source files
------------

// File: rtl/adc_seq_ctrl_if.sv
// Host and ADC-side signals of the ADC sweep sequencer, grouped as one bundle.
// The sequencer connects through the slave modport; the host/ADC side uses master.
interface adc_seq_ctrl_if #(
   parameter int NUM_CH = 8,
   parameter int DW     = 14
);
   logic                 init_req;
   logic                 start;
   logic                 stop;
   logic                 cont_mode;
   logic [NUM_CH-1:0]    ch_mask;
   logic                 int_l;
   logic                 sdi;
   logic                 sclk;
   logic                 fs;
   logic                 sdo;
   logic                 cs_l;
   logic                 cstart;
   logic                 busy;
   logic                 dat_valid;
   logic [NUM_CH*DW-1:0] dat_bus;
   logic                 timeout_err;

   modport master (
      output init_req, start, stop, cont_mode, ch_mask, int_l, sdi,
      input  sclk, fs, sdo, cs_l, cstart, busy, dat_valid, dat_bus, timeout_err
   );

   modport slave (
      input  init_req, start, stop, cont_mode, ch_mask, int_l, sdi,
      output sclk, fs, sdo, cs_l, cstart, busy, dat_valid, dat_bus, timeout_err
   );
endinterface

// File: rtl/adc_seq_ctrl.sv
// Serial ADC sweep sequencer: init/config frames, per-channel select frames,
// wait for end-of-conversion, then one read frame per enabled channel.
module adc_seq_ctrl #(
   parameter int          NUM_CH    = 8,
   parameter int          DW        = 14,
   parameter int          FRAME_LEN = 24,
   parameter logic [15:0] INIT_WORD = 16'hA000,
   parameter logic [15:0] CFG_WORD  = 16'hAA40,
   parameter logic [15:0] RD_CMD    = 16'hE000,
   parameter int          TIMEOUT   = 4095
) (
   input logic         clk,
   input logic         rst,
   adc_seq_ctrl_if.slave bus
);
   localparam int CW = $clog2(FRAME_LEN + 1);
   localparam int WW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, INIT, CFG, SEL, WAIT_INT, READ, DONE} state_t;

   state_t               state, state_n;
   logic [CW-1:0]        cnt, cnt_n;
   logic [3:0]           ch, ch_n;
   logic [WW-1:0]        wcnt, wcnt_n;
   logic [NUM_CH-1:0]    mask_l;
   logic                 cont_l, stop_l, tmo, tmo_n;
   logic                 latch, sample, wr;
   logic [1:0]           int_sync;
   logic                 int_d;
   logic [DW-1:0]        shreg, shreg_n;
   logic [NUM_CH*DW-1:0] dat;
   logic                 in_frame, fend, fall, busy;
   logic [15:0]          word;
   logic [3:0]           bit_idx;
   logic [4:0]           first_ch, next_ch;

   // Lowest enabled channel at or above 'from'; bit 4 set means none left.
   function automatic logic [4:0] find_ch(input logic [NUM_CH-1:0] m, input int from);
      logic [4:0] r;
      r = 5'h10;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (m[i] && i >= from) r = {1'b0, 4'(i)};
      return r;
   endfunction

   assign first_ch = find_ch(mask_l, 0);
   assign next_ch  = find_ch(mask_l, int'(ch) + 1);
   assign in_frame = state inside {INIT, CFG, SEL, READ};
   assign fend     = cnt == CW'(FRAME_LEN);
   assign bit_idx  = 4'(CW'(16) - cnt);
   assign busy     = state != IDLE;
   assign fall     = int_d & ~int_sync[1];
   assign shreg_n  = sample ? {shreg[DW-2:0], bus.sdi} : shreg;

   always_comb begin
      word = 16'h0000;
      case (state)
         INIT:    word = INIT_WORD;
         CFG:     word = CFG_WORD;
         SEL:     word = {ch, 12'h000};
         READ:    word = RD_CMD;
         default: word = 16'h0000;
      endcase
   end

   always_comb begin
      state_n = state;
      cnt_n   = '0;
      ch_n    = ch;
      wcnt_n  = '0;
      tmo_n   = 1'b0;
      latch   = 1'b0;
      sample  = 1'b0;
      wr      = 1'b0;
      if (in_frame && !fend) cnt_n = cnt + 1'b1;
      case (state)
         IDLE: begin
            if (bus.init_req) state_n = INIT;
            else if (bus.start && |bus.ch_mask) begin
               state_n = CFG;
               latch   = 1'b1;
            end
         end
         INIT: if (fend) state_n = IDLE;
         CFG: begin
            if (fend) begin
               state_n = SEL;
               ch_n    = first_ch[3:0];
            end
         end
         SEL: begin
            if (fend) begin
               if (!next_ch[4]) ch_n = next_ch[3:0];
               else begin
                  state_n = WAIT_INT;
                  ch_n    = first_ch[3:0];
               end
            end
         end
         WAIT_INT: begin
            wcnt_n = wcnt + 1'b1;
            if (fall) state_n = READ;
            else if (wcnt == WW'(TIMEOUT - 1)) begin
               state_n = IDLE;
               tmo_n   = 1'b1;
            end
         end
         READ: begin
            sample = cnt >= CW'(1) && cnt <= CW'(DW);
            if (fend) begin
               wr = 1'b1;
               if (!next_ch[4]) ch_n = next_ch[3:0];
               else state_n = DONE;
            end
         end
         DONE: begin
            // A stop arriving in this very cycle still ends continuous mode.
            if (cont_l && !(stop_l || bus.stop)) begin
               state_n = SEL;
               ch_n    = first_ch[3:0];
            end else state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         ch       <= '0;
         wcnt     <= '0;
         mask_l   <= '0;
         cont_l   <= 1'b0;
         stop_l   <= 1'b0;
         tmo      <= 1'b0;
         int_sync <= 2'b11;
         int_d    <= 1'b1;
         dat      <= '0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         ch       <= ch_n;
         wcnt     <= wcnt_n;
         tmo      <= tmo_n;
         int_sync <= {int_sync[0], bus.int_l};
         int_d    <= int_sync[1];
         if (latch) begin
            mask_l <= bus.ch_mask;
            cont_l <= bus.cont_mode;
         end
         if (state_n == IDLE) stop_l <= 1'b0;
         else if (busy && bus.stop) stop_l <= 1'b1;
         for (int k = 0; k < NUM_CH; k++)
            if (wr && ch == 4'(k)) dat[k*DW +: DW] <= shreg_n;
      end
   end

   always_ff @(posedge clk) shreg <= shreg_n;

   assign bus.sclk        = clk;
   assign bus.cstart      = 1'b1;
   assign bus.cs_l        = ~busy;
   assign bus.busy        = busy;
   assign bus.fs          = in_frame && cnt == '0;
   assign bus.sdo         = (in_frame && cnt >= CW'(1) && cnt <= CW'(16)) ? word[bit_idx] : 1'b0;
   assign bus.dat_valid   = state == DONE;
   assign bus.dat_bus     = dat;
   assign bus.timeout_err = tmo;
endmodule
